tbus_mem_responder: RTL and testbench
=====================================

# tbus_mem_responder

Responder end of the trinity bus (tbus): accepts one load/store request at a time from the memblock initiator, holds it for a configurable access latency, performs it against an internal 64-bit-wide SRAM, and returns read data with a one-cycle `tbus_operation_done` pulse. It sits where the dcache attaches and is used both as the simulation data memory and as the baseline dcache stand-in. It honours the memblock flush line so that squashed requests do not complete.

## Interface
- `LATENCY`, 2: extra wait cycles between accept and the SRAM access; 0 is legal.
- `MEM_ADDR_W`, 16: SRAM depth is 2^MEM_ADDR_W 64-bit words.
- `MEM_BASE`, 64'h8000_0000: byte address mapped to SRAM word 0.
- Clock and reset: one clock; reset is asynchronous and active-low. Ports are `clock` and `reset_n`.
- `clock`  in  1  clock.
- `reset_n`  in  1  async active-low reset.
- `tbus_index_valid`  in  1  request valid.
- `tbus_index_ready`  out  1  request accepted when valid & ready.
- `tbus_index`  in  `RESULT_RANGE` (64)  byte address.
- `tbus_write_data`  in  64  store data, already lane-shifted by the initiator.
- `tbus_write_mask`  in  64  bit-granular write enable.
- `tbus_operation_type`  in  `TBUS_OPTYPE_RANGE`  `TBUS_READ` / `TBUS_WRITE`.
- `tbus_read_data`  out  64  full aligned doubleword; valid only with done.
- `tbus_operation_done`  out  1  one-cycle completion pulse.
- `flush`  in  1  memblock flush (driven by memblock2dcache_flush).
- `tbus_resp_error`  out  1  present only with `TBUS_RESP_ERR_EN`.

## Operation
- FSM states:
  - IDLE: `tbus_index_ready`=1. On valid & ~flush, latch address, data, mask and optype. Go to WAIT if LATENCY>0, otherwise go to ACCESS. Valid & flush in the same cycle: the request is dropped and the state stays IDLE.
  - WAIT: down-counter loaded with LATENCY-1. Go to ACCESS when the count reaches 0. Counter width is $clog2(LATENCY+1), minimum 1.
  - ACCESS: drive the SRAM with word index (addr − MEM_BASE)[MEM_ADDR_W+2:3]. Reads use a synchronous read. Writes update mem = (mem & ~mask) | (wdata & mask). Any optype other than READ/WRITE performs no SRAM access. Always go to RESP.
  - RESP: `tbus_operation_done`=1. `tbus_read_data` = SRAM read word for READ; 0 for WRITE and other optypes. Go to IDLE.
- `tbus_index_ready` = (state==IDLE). `tbus_index_ready` must not depend on valid.
- `tbus_read_data` is 0 in every state except RESP.
- Address bits [2:0] are ignored; the initiator does lane extraction.
- Flush handling:
  - Flush in WAIT: abort to IDLE. No SRAM access, no done.
  - Flush in ACCESS: the SRAM access still occurs (a write lands). RESP is skipped; go to IDLE and suppress done.
  - Flush in RESP: done is forced to 0; go to IDLE.
  - Flush in IDLE with no valid: no effect.
- Reset mid-operation: return to IDLE immediately. The latched request is discarded, no done is issued, and SRAM contents are not cleared.

## Timing
- Reset values: `tbus_index_ready`=1, `tbus_operation_done`=0, `tbus_read_data`=0, `tbus_resp_error`=0, state=IDLE, counter=0.
- Accept in cycle T: ACCESS occurs at T+1+LATENCY, done at T+2+LATENCY, ready again at T+3+LATENCY.
- Throughput: one request per LATENCY+3 cycles.
- No back-to-back accept: ready is low from T+1 until return to IDLE.
- Done is exactly one cycle and is never asserted twice for a single accept.

## Configuration
- `TBUS_RESP_ERR_EN` defined:
  - Adds the `tbus_resp_error` port.
  - A request whose address is outside [MEM_BASE, MEM_BASE + 8·2^MEM_ADDR_W) performs no SRAM access.
  - It still completes with done, `tbus_read_data`=0 and `tbus_resp_error`=1 in the RESP cycle only.
- Undefined: no error port; out-of-range addresses wrap modulo the SRAM size.

## Structure
- Shared package (alongside `defines.sv`): the FSM state encoding (IDLE/WAIT/ACCESS/RESP, 2 bits). `TBUS_READ`, `TBUS_WRITE` and `TBUS_OPTYPE_RANGE` are reused from `defines.sv` and are not redefined.
- One sub-module, `tbus_sram`: 2^MEM_ADDR_W × 64, single port, synchronous read, bit-masked write, no reset on the array.

## Test plan
- Reset, then write addr 0x8000_0010, data 0x1122334455667788, mask all-ones. Then read the same address → done at T+4 (LATENCY=2) with read_data 0x1122334455667788.
- Write a byte: data 0xAB<<24, mask 0xFF<<24 at 0x8000_0010 (over the previous value), then read → 0x11223344AB667788.
- LATENCY=0 build: read → done at T+2; ready is low at T+1 and T+2 and high at T+3.
- Flush during WAIT of a write to 0x8000_0020 (prior content 0) → no done; a subsequent read returns 0. Valid & flush in IDLE → ready stays 1 and no done follows.
- Flush during ACCESS of a write of 0x55 → no done, but a following read returns 0x55.
- `TBUS_RESP_ERR_EN` defined: read at 0x7FFF_FFF8 → done with read_data 0 and error=1 for one cycle. Undefined: read at MEM_BASE + 8·2^16 returns word 0.

Source files
------------

// File: rtl/tbus_mem_responder_pkg.sv
// tbus_mem_responder_pkg: FSM state encoding for the tbus memory responder.
// Optional feature macro used by this slice: TBUS_RESP_ERR_EN.

// Fallbacks for builds that do not pull in defines.sv.
`ifndef TBUS_OPTYPE_RANGE
`define TBUS_OPTYPE_RANGE 1:0
`endif
`ifndef TBUS_READ
`define TBUS_READ 2'b00
`endif
`ifndef TBUS_WRITE
`define TBUS_WRITE 2'b01
`endif
`ifndef RESULT_RANGE
`define RESULT_RANGE 63:0
`endif

package tbus_mem_responder_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT   = 2'd1,
        S_ACCESS = 2'd2,
        S_RESP   = 2'd3
    } tbus_state_e;

    typedef logic [`TBUS_OPTYPE_RANGE] tbus_optype_t;

    // Wait counter width: enough to hold LATENCY-1, never below one bit.
    function automatic int cnt_width(input int lat);
        int w;
        w = (lat > 0) ? $clog2(lat + 1) : 1;
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/tbus_mem_responder_sram.sv
// tbus_sram: single-port 64-bit SRAM with synchronous read and bit-masked write.
// Optional feature macro: none (the array is never reset).

module tbus_sram #(
    parameter int ADDR_W = 16
) (
    input  logic              clock,
    input  logic              en,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [63:0]       wdata,
    input  logic [63:0]       wmask,
    output logic [63:0]       rdata
);

    logic [63:0] mem [2**ADDR_W];

    // Masked write-through-old-value and registered read of the addressed word.
    always_ff @(posedge clock) begin
        if (en) begin
            if (we) begin
                mem[addr] <= (mem[addr] & ~wmask) | (wdata & wmask);
            end
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/tbus_mem_responder.sv
// tbus_mem_responder: one-at-a-time tbus load/store responder with latency.
// Optional feature macro: TBUS_RESP_ERR_EN (out-of-range error response).

module tbus_mem_responder
    import tbus_mem_responder_pkg::*;
#(
    parameter int          LATENCY    = 2,
    parameter int          MEM_ADDR_W = 16,
    parameter logic [63:0] MEM_BASE   = 64'h8000_0000
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic                      tbus_index_valid,
    output logic                      tbus_index_ready,
    input  logic [`RESULT_RANGE]      tbus_index,
    input  logic [63:0]               tbus_write_data,
    input  logic [63:0]               tbus_write_mask,
    input  logic [`TBUS_OPTYPE_RANGE] tbus_operation_type,
    output logic [63:0]               tbus_read_data,
    output logic                      tbus_operation_done,
    input  logic                      flush
`ifdef TBUS_RESP_ERR_EN
    ,
    output logic                      tbus_resp_error
`endif
);

    localparam int CW = cnt_width(LATENCY);
    localparam logic [CW-1:0] CNT_LOAD = CW'((LATENCY > 0) ? LATENCY - 1 : 0);

    tbus_state_e state, state_n;
    logic [CW-1:0] cnt, cnt_n;

    logic [MEM_ADDR_W-1:0] req_word;
    logic [63:0]           req_data;
    logic [63:0]           req_mask;
    tbus_optype_t          req_op;
    logic                  req_oob;

    logic                  accept;
    logic [MEM_ADDR_W-1:0] word_in;
    logic                  oob_in;
    logic                  is_rd;
    logic                  is_wr;
    logic                  sram_en;
    logic                  sram_we;
    logic [63:0]           sram_q;
    logic                  unused_ok;

    assign accept  = tbus_index_valid & ~flush & (state == S_IDLE);
    assign word_in = tbus_index[MEM_ADDR_W+2:3] - MEM_BASE[MEM_ADDR_W+2:3];

`ifdef TBUS_RESP_ERR_EN
    logic [63:0] off_in;
    assign off_in = tbus_index - MEM_BASE;
    assign oob_in = |off_in[63:MEM_ADDR_W+3];
`else
    assign oob_in = 1'b0;
`endif

    // Byte lanes are extracted by the initiator; high bits only matter for range.
    assign unused_ok = ^{tbus_index[2:0], tbus_index[63:MEM_ADDR_W+3]};

    // State and wait-counter registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    // Capture the request on accept; held until the next accept.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            req_word <= '0;
            req_data <= '0;
            req_mask <= '0;
            req_op   <= `TBUS_READ;
            req_oob  <= 1'b0;
        end else if (accept) begin
            req_word <= word_in;
            req_data <= tbus_write_data;
            req_mask <= tbus_write_mask;
            req_op   <= tbus_operation_type;
            req_oob  <= oob_in;
        end
    end

    // Next-state: latency wait, one access cycle, one response cycle; flush aborts.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        unique case (state)
            S_IDLE: begin
                if (tbus_index_valid && !flush) begin
                    state_n = (LATENCY > 0) ? S_WAIT : S_ACCESS;
                    cnt_n   = CNT_LOAD;
                end
            end
            S_WAIT: begin
                if (flush) begin
                    state_n = S_IDLE;
                end else if (cnt == '0) begin
                    state_n = S_ACCESS;
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            S_ACCESS: begin
                state_n = flush ? S_IDLE : S_RESP;
            end
            S_RESP: begin
                state_n = S_IDLE;
            end
        endcase
    end

    assign is_rd   = (req_op == `TBUS_READ);
    assign is_wr   = (req_op == `TBUS_WRITE);
    assign sram_en = (state == S_ACCESS) & ~req_oob & (is_rd | is_wr);
    assign sram_we = sram_en & is_wr;

    tbus_sram #(
        .ADDR_W(MEM_ADDR_W)
    ) u_sram (
        .clock (clock),
        .en    (sram_en),
        .we    (sram_we),
        .addr  (req_word),
        .wdata (req_data),
        .wmask (req_mask),
        .rdata (sram_q)
    );

    assign tbus_index_ready    = (state == S_IDLE);
    assign tbus_operation_done = (state == S_RESP) & ~flush;
    assign tbus_read_data      = ((state == S_RESP) && is_rd && !req_oob)
                                 ? sram_q : '0;

`ifdef TBUS_RESP_ERR_EN
    assign tbus_resp_error = (state == S_RESP) & req_oob;
`endif

endmodule

// File: tb/tb_tbus_mem_responder.sv
// tb_tbus_mem_responder: randomized bench with a transaction-level memory model.
// Optional feature macro: TBUS_RESP_ERR_EN (error port present and checked).

`ifndef TBUS_OPTYPE_RANGE
`define TBUS_OPTYPE_RANGE 1:0
`endif
`ifndef TBUS_READ
`define TBUS_READ 2'b00
`endif
`ifndef TBUS_WRITE
`define TBUS_WRITE 2'b01
`endif

module tb_tbus_mem_responder;

    localparam int          LAT   = 2;
    localparam int          AW    = 16;
    localparam int          DEPTH = 1 << AW;
    localparam logic [63:0] BASE  = 64'h8000_0000;

    localparam int M_NONE = 0;
    localparam int M_WAIT = 1;
    localparam int M_ACC  = 2;
    localparam int M_RESP = 3;
    localparam int M_IDLE = 4;

    logic                      clock = 1'b0;
    logic                      reset_n = 1'b0;
    logic                      valid = 1'b0;
    logic                      ready;
    logic [63:0]               index = '0;
    logic [63:0]               wdata = '0;
    logic [63:0]               wmask = '0;
    logic [`TBUS_OPTYPE_RANGE] optype = `TBUS_READ;
    logic [63:0]               rdata;
    logic                      done;
    logic                      flush = 1'b0;
`ifdef TBUS_RESP_ERR_EN
    logic                      err;
`endif

    int n_chk = 0;
    int n_err = 0;

    logic [63:0] mem_m [int];

    tbus_mem_responder #(
        .LATENCY    (LAT),
        .MEM_ADDR_W (AW),
        .MEM_BASE   (BASE)
    ) dut (
        .clock               (clock),
        .reset_n             (reset_n),
        .tbus_index_valid    (valid),
        .tbus_index_ready    (ready),
        .tbus_index          (index),
        .tbus_write_data     (wdata),
        .tbus_write_mask     (wmask),
        .tbus_operation_type (optype),
        .tbus_read_data      (rdata),
        .tbus_operation_done (done),
        .flush               (flush)
`ifdef TBUS_RESP_ERR_EN
        ,
        .tbus_resp_error     (err)
`endif
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int word_of(input logic [63:0] a);
        logic [63:0] off;
        off = a - BASE;
        return int'((off >> 3) & 64'(DEPTH - 1));
    endfunction

    function automatic bit is_oob(input logic [63:0] a);
`ifdef TBUS_RESP_ERR_EN
        logic [63:0] off;
        off = a - BASE;
        return off >= 64'(8 * DEPTH);
`else
        return (a == 64'h0) && (a != 64'h0);
`endif
    endfunction

    function automatic logic [63:0] peek(input int w);
        return mem_m.exists(w) ? mem_m[w] : 64'h0;
    endfunction

    // One request, observed over LAT+4 cycles; mode chooses where flush lands.
    task automatic do_req(input logic [63:0] a, input logic [63:0] d,
                          input logic [63:0] m,
                          input logic [`TBUS_OPTYPE_RANGE] op,
                          input int mode_in);
        int  mode;
        int  fk;
        int  endk;
        int  w;
        bit  oob;
        bit  land;
        bit  dn;
        logic [63:0] exp_rd;
        mode = mode_in;
        if (mode == M_WAIT && LAT == 0) mode = M_NONE;
        oob = is_oob(a);
        w   = word_of(a);
        case (mode)
            M_WAIT:  fk = int'($urandom_range(LAT, 1));
            M_ACC:   fk = LAT + 1;
            M_RESP:  fk = LAT + 2;
            M_IDLE:  fk = 0;
            default: fk = -1;
        endcase
        case (mode)
            M_IDLE:  endk = 0;
            M_WAIT:  endk = fk + 1;
            M_ACC:   endk = LAT + 2;
            default: endk = LAT + 3;
        endcase
        land = (mode == M_NONE || mode == M_ACC || mode == M_RESP) && !oob;
        exp_rd = (op == `TBUS_READ && !oob) ? peek(w) : 64'h0;
        for (int k = 0; k <= LAT + 3; k++) begin
            @(negedge clock);
            valid  = (k == 0);
            index  = a;
            wdata  = d;
            wmask  = m;
            optype = op;
            flush  = (k == fk);
            #1;
            dn = (mode == M_NONE) && (k == LAT + 2);
            chk("ready", {63'h0, ready}, {63'h0, (k == 0 || k >= endk)});
            chk("done", {63'h0, done}, {63'h0, dn});
            if (!(k == fk && k == LAT + 2)) begin
                chk("rdata", rdata, dn ? exp_rd : 64'h0);
`ifdef TBUS_RESP_ERR_EN
                chk("err", {63'h0, err}, {63'h0, dn && oob});
`endif
            end
        end
        valid = 1'b0;
        flush = 1'b0;
        if (land && op == `TBUS_WRITE) begin
            mem_m[w] = (peek(w) & ~m) | (d & m);
        end
    endtask

    // Reset pulled during WAIT of a write: nothing lands, no done appears.
    task automatic reset_mid_write(input int w, input logic [63:0] d);
        @(negedge clock);
        valid  = 1'b1;
        index  = BASE + 64'(8 * w);
        wdata  = d;
        wmask  = '1;
        optype = `TBUS_WRITE;
        @(negedge clock);
        valid = 1'b0;
        #1;
        reset_n = 1'b0;
        #1;
        chk("rst_ready", {63'h0, ready}, 64'h1);
        chk("rst_done", {63'h0, done}, 64'h0);
        @(negedge clock);
        reset_n = 1'b1;
        for (int k = 0; k < LAT + 3; k++) begin
            @(negedge clock);
            #1;
            chk("rst_idle_done", {63'h0, done}, 64'h0);
            chk("rst_idle_ready", {63'h0, ready}, 64'h1);
        end
    endtask

    logic [63:0] a_r;
    logic [63:0] d_r;
    logic [63:0] m_r;
    logic [`TBUS_OPTYPE_RANGE] op_r;
    int r;
    int md;

    initial begin
        #1;
        chk("reset_ready", {63'h0, ready}, 64'h1);
        chk("reset_done", {63'h0, done}, 64'h0);
        chk("reset_rdata", rdata, 64'h0);
`ifdef TBUS_RESP_ERR_EN
        chk("reset_err", {63'h0, err}, 64'h0);
`endif
        repeat (3) @(negedge clock);
        reset_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            do_req(BASE + 64'(8 * i), {$urandom, $urandom}, '1, `TBUS_WRITE,
                   M_NONE);
        end
        do_req(BASE + 64'h20, 64'h0, '1, `TBUS_WRITE, M_NONE);

        do_req(64'h8000_0010, 64'h1122334455667788, '1, `TBUS_WRITE, M_NONE);
        do_req(64'h8000_0010, 64'h0, 64'h0, `TBUS_READ, M_NONE);
        chk("model_full", peek(2), 64'h1122334455667788);
        do_req(64'h8000_0010, 64'hAB << 24, 64'hFF << 24, `TBUS_WRITE, M_NONE);
        do_req(64'h8000_0013, 64'h0, 64'h0, `TBUS_READ, M_NONE);
        chk("model_byte", peek(2), 64'h11223344AB667788);

        do_req(64'h8000_0020, 64'hDEAD_BEEF, '1, `TBUS_WRITE, M_WAIT);
        do_req(64'h8000_0020, 64'h0, 64'h0, `TBUS_READ, M_NONE);
        do_req(64'h8000_0018, 64'h0, 64'h0, `TBUS_READ, M_IDLE);
        do_req(64'h8000_0020, 64'h55, '1, `TBUS_WRITE, M_ACC);
        do_req(64'h8000_0020, 64'h0, 64'h0, `TBUS_READ, M_NONE);
        chk("model_acc", peek(4), 64'h55);
        do_req(64'h8000_0028, 64'h77, 64'hFF, `TBUS_WRITE, M_RESP);
        do_req(64'h8000_0028, 64'h0, 64'h0, `TBUS_READ, M_NONE);

        do_req(64'h7FFF_FFF8, 64'h0, 64'h0, `TBUS_READ, M_NONE);
        do_req(BASE + 64'(8 * DEPTH), 64'h0, 64'h0, `TBUS_READ, M_NONE);
        do_req(BASE + 64'(8 * DEPTH) + 64'h10, 64'h0, 64'h0, `TBUS_READ,
               M_NONE);
        do_req(64'h8000_0030, 64'h0, 64'h0, 2'd2, M_NONE);

        reset_mid_write(6, 64'hCAFE_F00D_0000_1111);
        do_req(64'h8000_0030, 64'h0, 64'h0, `TBUS_READ, M_NONE);

        for (int n = 0; n < 150; n++) begin
            a_r = BASE + 64'(8 * $urandom_range(7, 0)) + 64'($urandom_range(7, 0));
            r = int'($urandom_range(9, 0));
            if (r == 0) a_r = a_r + 64'(8 * DEPTH);
            if (r == 1) a_r = 64'h7FFF_FFF8;
            d_r = {$urandom, $urandom};
            case ($urandom_range(2, 0))
                0:       m_r = '1;
                1:       m_r = 64'hFF << (8 * $urandom_range(7, 0));
                default: m_r = {$urandom, $urandom};
            endcase
            r = int'($urandom_range(9, 0));
            if (r < 4)      op_r = `TBUS_READ;
            else if (r < 8) op_r = `TBUS_WRITE;
            else            op_r = (r == 8) ? 2'd2 : 2'd3;
            r  = int'($urandom_range(9, 0));
            md = (r < 6) ? M_NONE : r - 5;
            do_req(a_r, d_r, m_r, op_r, md);
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
